// File: rtl/pipe_adder_nbit.sv
// Pipelined WIDTH-bit add/subtract, one SLICE-bit slice per stage.
// Valid/ready stream in and out with a single global stall (adv).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (a, b, cin, sub)
//   out_valid/out_ready result handshake (sum, cout, ovf)
module pipe_adder_nbit #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic             adv;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0] x_in [STAGES];
    logic [WIDTH-1:0] y_in [STAGES];
    logic [WIDTH-1:0] x_q  [STAGES];
    logic [WIDTH-1:0] y_q  [STAGES];
    logic             ovf_q;

    assign out_valid = v_q[LAST];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;

    assign sum  = x_q[LAST];
    assign cout = c_q[LAST];
    assign ovf  = ovf_q;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        // x carries finished sum slices below and raw A slices above;
        // y carries the conditioned B operand.
        if (g == 0) begin : g_head
            assign v_in[g] = in_valid;
            assign x_in[g] = a;
            assign y_in[g] = sub ? ~b : b;
            assign c_in[g] = cin ^ sub;
        end else begin : g_body
            assign v_in[g] = v_q[g-1];
            assign x_in[g] = x_q[g-1];
            assign y_in[g] = y_q[g-1];
            assign c_in[g] = c_q[g-1];
        end

        logic [SLICE:0]   part;
        logic [WIDTH-1:0] merged;
        logic             v_r;
        logic             c_r;
        logic [WIDTH-1:0] x_r;
        logic [WIDTH-1:0] y_r;
        logic             unused_y;

        assign part = {1'b0, x_in[g][g*SLICE +: SLICE]}
                    + {1'b0, y_in[g][g*SLICE +: SLICE]}
                    + {{SLICE{1'b0}}, c_in[g]};

        always_comb begin
            merged = x_in[g];
            merged[g*SLICE +: SLICE] = part[SLICE-1:0];
        end

        // Data only loads with a valid beat so outputs hold
        // their last value across bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                x_r <= '0;
                y_r <= '0;
            end else if (adv) begin
                v_r <= v_in[g];
                if (v_in[g]) begin
                    c_r <= part[SLICE];
                    x_r <= merged;
                    y_r <= y_in[g];
                end
            end
        end

        assign v_q[g]   = v_r;
        assign c_q[g]   = c_r;
        assign x_q[g]   = x_r;
        assign y_q[g]   = y_r;
        assign unused_y = ^y_q[g];

        if (g == LAST) begin : g_tail
            // Carry into the MSB is a^b^s there; xor with carry-out.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv && v_in[g]) begin
                    ovf_q <= x_in[g][WIDTH-1] ^ y_in[g][WIDTH-1]
                           ^ part[SLICE-1] ^ part[SLICE];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_adder_nbit.sv
// Bench for pipe_adder_nbit: directed, reset, backpressure, random,
// and a parameter sweep against an arithmetic reference model.
module tb_pipe_adder_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [33:0] exp;
        int          t;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, {ovf, cout, sum[31:0]}.
    function automatic logic [33:0] model(int w, logic [31:0] x,
                                          logic [31:0] y,
                                          logic ci, logic sb);
        longint m, ux, uy, r, sx, sy, sr, c;
        logic co, ov;
        logic [31:0] s;
        m  = longint'(1) << w;
        ux = longint'(x) & (m - 1);
        uy = longint'(y) & (m - 1);
        c  = ci ? 1 : 0;
        if (!sb) begin
            r  = ux + uy + c;
            co = (r >= m);
        end else begin
            r  = ux - uy - c;
            co = (ux >= uy + c);
        end
        s  = 32'(r & (m - 1));
        sx = (ux >= m / 2) ? ux - m : ux;
        sy = (uy >= m / 2) ? uy - m : uy;
        sr = sb ? sx - sy - c : sx + sy + c;
        ov = (sr < -(m / 2)) || (sr >= m / 2);
        return {ov, co, s};
    endfunction

    function automatic logic [33:0] exp34(logic ov, logic co,
                                          logic [15:0] s);
        return {ov, co, 16'h0, s};
    endfunction

    // Main instance, WIDTH=16 STAGES=4
    logic        in_valid, in_ready, cin, sub;
    logic        out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    pipe_adder_nbit #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    exp_t q[$];
    bit   lat_on = 1'b0;
    int   n_out  = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                check("stale_out", out_valid, 0);
            end else begin
                e = q.pop_front();
                check("sum", sum, e.exp[15:0]);
                check("cout", cout, e.exp[32]);
                check("ovf", ovf, e.exp[33]);
                if (lat_on) check("latency", cyc - e.t, 4);
            end
        end
    end

    task automatic send(input logic [15:0] xa, input logic [15:0] xb,
                        input logic ci, input logic sb,
                        input logic [33:0] e);
        int i;
        in_valid = 1'b1;
        a = xa; b = xb; cin = ci; sub = sb;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!in_ready && i < 200);
        if (!in_ready) check("accept_timeout", in_ready, 1);
        else q.push_back('{e, cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        logic [15:0] xa, xb;
        logic ci, sb;
        xa = 16'($urandom);
        xb = 16'($urandom);
        ci = 1'($urandom);
        sb = 1'($urandom);
        send(xa, xb, ci, sb, model(16, {16'h0, xa}, {16'h0, xb}, ci, sb));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (q.size() > 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, q.size(), 0);
    endtask

    // Parameter sweep instances
    bit sweep_go  = 1'b0;
    int sweep_fin = 0;

    for (genvar c = 0; c < 3; c++) begin : g_sw
        localparam int W = (c == 2) ? 32 : 16;
        localparam int S = (c == 0) ? 1 : (c == 1) ? 16 : 8;

        logic         iv, ir, ci, sb, ov, orr, co, vf;
        logic [W-1:0] xa, xb, sm;
        exp_t         sq[$];
        int           got = 0;

        pipe_adder_nbit #(.WIDTH(W), .STAGES(S)) u_sw (
            .clk(clk), .rst_n(rst_n),
            .in_valid(iv), .in_ready(ir),
            .a(xa), .b(xb), .cin(ci), .sub(sb),
            .out_valid(ov), .out_ready(orr),
            .sum(sm), .cout(co), .ovf(vf)
        );

        initial begin
            iv = 1'b0; xa = '0; xb = '0; ci = 1'b0; sb = 1'b0;
            orr = 1'b1;
            wait (sweep_go);
            @(posedge clk);
            #1;
            for (int i = 0; i < 100; i++) begin
                iv = 1'b1;
                xa = W'($urandom);
                xb = W'($urandom);
                ci = 1'($urandom);
                sb = 1'($urandom);
                @(posedge clk);
                #1;
            end
            iv = 1'b0;
            repeat (S + 4) @(posedge clk);
            #1;
            check($sformatf("sw%0d_count", c), got, 100);
            check($sformatf("sw%0d_left", c), sq.size(), 0);
            sweep_fin++;
        end

        always @(negedge clk) begin : swmon
            exp_t e;
            if (rst_n && iv) begin
                check($sformatf("sw%0d_ready", c), ir, 1);
                if (ir)
                    sq.push_back('{model(W, 32'(xa), 32'(xb), ci, sb), cyc});
            end
            if (rst_n && ov && orr) begin
                got++;
                if (sq.size() == 0) begin
                    check($sformatf("sw%0d_stale", c), ov, 0);
                end else begin
                    e = sq.pop_front();
                    check($sformatf("sw%0d_sum", c), sm, e.exp[W-1:0]);
                    check($sformatf("sw%0d_cout", c), co, e.exp[32]);
                    check($sformatf("sw%0d_ovf", c), vf, e.exp[33]);
                    check($sformatf("sw%0d_lat", c), cyc - e.t, S);
                end
            end
        end
    end

    initial begin
        int          base, k;
        logic [15:0] hold;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with hand-derived results
        lat_on = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, exp34(1'b0, 1'b1, 16'h0000));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, exp34(1'b1, 1'b0, 16'h8000));
        send(16'h1234, 16'h4321, 1'b1, 1'b0, exp34(1'b0, 1'b0, 16'h5556));
        send(16'h0005, 16'h0007, 1'b0, 1'b1, exp34(1'b0, 1'b0, 16'hFFFE));
        send(16'h8000, 16'h0001, 1'b0, 1'b1, exp34(1'b1, 1'b1, 16'h7FFF));
        idle(8);
        drain("dir_drain");

        // Reset with three transactions in flight
        repeat (3) send_rand();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_ready", in_ready, 1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send_rand();
        idle(6);
        drain("post_rst_drain");

        // Backpressure: 8 back-to-back, 5-cycle stall on first result
        lat_on = 1'b0;
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand();
                in_valid = 1'b0;
            end
            begin
                k = 0;
                do begin
                    @(posedge clk);
                    #1;
                    k++;
                end while (!out_valid && k < 100);
                check("bp_valid_rise", out_valid, 1);
                out_ready = 1'b0;
                hold = sum;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_hold", sum, hold);
                    check("bp_valid_hold", out_valid, 1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_count", n_out - base, 8);

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(3) == 0) idle(1);
                    send_rand();
                end
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("rnd_drain");

        // Full-rate stream: latency 4, one result per clock
        lat_on = 1'b1;
        for (int i = 0; i < 50; i++) send_rand();
        idle(1);
        drain("full_drain");
        lat_on = 1'b0;

        sweep_go = 1'b1;
        k = 0;
        while (sweep_fin < 3 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        check("sweep_done", sweep_fin, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_adder_nbit.md
Name: pipe_adder_nbit

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES slices of WIDTH/STAGES bits, one slice per clock, with the carry registered between slices.
- Supports add and subtract per transaction, with carry-out and signed-overflow flags.
- Sits on a valid/ready stream between the operand source and the result consumer in the datapath.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; slice width SLICE = WIDTH/STAGES. STAGES=1 is legal and gives a single registered add.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block accepts a transaction this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (subtract).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out (add) / not-borrow (subtract).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset: asynchronous on rst_n low; all stage valid bits, carry registers and data registers clear to 0.
  - After reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
  - rst_n deassertion takes effect on the next clk edge.
  - Reset mid-operation discards every in-flight transaction; no partial result is ever presented.
- Operand conditioning at capture:
  - Effective B is b when sub=0 and ~b when sub=1.
  - Effective carry-in is cin when sub=0 and ~cin when sub=1.
  - Subtract therefore computes a - b - cin mod 2^WIDTH.
- Pipeline:
  - Stage k (0..STAGES-1) adds bits [k*SLICE +: SLICE] of A and effective B plus the registered carry from stage k-1 (stage 0 uses the effective carry-in).
  - Each stage registers its SLICE-bit partial sum and carry-out.
  - Not-yet-added upper slices of A and B travel forward skewed.
  - Already-computed lower sum slices travel forward aligned.
  - Each stage has one valid bit.
- Latency: a transaction accepted at edge N is presented with out_valid=1 after edge N+STAGES, provided no stall occurs.
- Flow control, global stall:
  - adv = ~out_valid | out_ready; in_ready = adv, combinationally.
  - Transfer in occurs on in_valid & in_ready; transfer out occurs on out_valid & out_ready.
  - When adv=1, every stage shifts one position and stage 0 loads the new transaction (valid = in_valid).
  - When adv=0, all registers hold.
  - Bubbles are not compressed.
  - Throughput is 1 transaction per clock while out_ready=1.
- Outputs:
  - sum, cout and ovf are registered, come from the final stage, and are held stable while out_valid=1 and out_ready=0.
  - cout is the final-slice carry.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. The final stage computes this internally; it is not an extra stage.
- Simultaneous events: output drain and input accept in the same cycle are legal and lose no data. Full pipeline with out_ready=1 and in_valid=1 sustains one result in and one out per clock.
- Wrap-around: sum is always modulo 2^WIDTH. Overflow is reported only via cout and ovf; it is never saturated.
- Mode and operands are captured per transaction; changing sub between transactions needs no flush.
- When out_valid=0, output data values are don't-care for checking. RTL keeps them holding their last value.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Reset check: pulse rst_n low mid-stream with 3 transactions in flight → out_valid=0, sum=0 immediately; no stale result appears after release; first new result arrives 4 clocks after acceptance.
- Add with carry ripple through all slices: a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0 on the 4th edge after accept.
- Add signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. Also a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0, ovf=0.
- Subtract: a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0 (borrow). Also a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1, cout=1.
- Backpressure: stream 8 back-to-back transactions and hold out_ready=0 for 5 cycles once out_valid rises → in_ready=0 throughout the stall, sum held stable, all 8 results emerge in order with none lost or duplicated.
- Parameter sweep with random stimulus: STAGES=1 and STAGES=16 (WIDTH=16), plus WIDTH=32/STAGES=8 → results match a reference model; latency equals STAGES; throughput is 1/clk with out_ready held high.
